// File: rtl/ram_unscramble_checker.sv
`default_nettype none
// ============================================================================
// Module   : ram_unscramble_checker
// Brief    : Sweeps an inclusive address range, reads the scrambled RAM and
//            the reference ROM, undoes the write-side bit permutation, streams
//            the recovered bytes and tallies mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module ram_unscramble_checker #(
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rom_cs_n,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              ram_cs_n,
  output logic              ram_oe,
  output logic              ram_ws,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int CNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          dout_q, dout_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;

  logic [7:0]          w_unscr;
  logic                w_mismatch;
  logic                w_active;

  // Inverse of the writer's permutation s = {r0,r7,r1,r6,r2,r5,r3,r4}
  assign w_unscr    = {ram_data[6], ram_data[4], ram_data[2], ram_data[0],
                       ram_data[1], ram_data[3], ram_data[5], ram_data[7]};
  assign w_mismatch = (w_unscr != rom_data);

  // Next-state and datapath updates; data is captured on the WAIT->SAMPLE
  // edge so the address has been stable for SETUP plus all WAIT cycles.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = '0;
          if (start_addr <= end_addr) begin
            addr_d  = start_addr;
            end_d   = end_addr;
            ferr_d  = '0;
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYC);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          dout_d  = w_unscr;
          state_d = S_SAMPLE;
          if (w_mismatch) begin
            if (err_q == '0) begin
              ferr_d = addr_q;
            end
            if (err_q != {(ADDR_W+1){1'b1}}) begin
              err_d = err_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        // Terminate on equality so the top address never wraps to zero
        if (addr_q == end_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // Memory controls decode straight from the state register, so they drop
  // to idle the instant reset is asserted.
  assign w_active       = (state_q == S_SETUP) || (state_q == S_WAIT) ||
                          (state_q == S_SAMPLE);
  assign rom_cs_n       = ~w_active;
  assign ram_cs_n       = ~w_active;
  assign rom_oe         = w_active;
  assign ram_oe         = w_active;
  assign ram_ws         = 1'b0;
  assign rom_addr       = addr_q;
  assign ram_addr       = addr_q;
  assign busy           = w_active;
  assign done           = (state_q == S_DONE);
  assign dout_valid     = (state_q == S_SAMPLE);
  assign dout           = dout_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_unscramble_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_unscramble_checker
// Brief    : Directed self-checking bench for ram_unscramble_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_unscramble_checker;

  localparam int ADDR_W   = 5;
  localparam int WAIT_CYC = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic              rom_cs_n, rom_oe, ram_cs_n, ram_oe, ram_ws;
  logic [ADDR_W-1:0] rom_addr, ram_addr;
  logic [7:0]        rom_data, ram_data;
  logic              busy, done, dout_valid;
  logic [7:0]        dout;
  logic [ADDR_W:0]   err_cnt;
  logic [ADDR_W-1:0] first_err_addr;

  logic [7:0] rom_mem [32];
  logic [7:0] ram_mem [32];
  logic [7:0] exp_mem [32];
  logic [7:0] dout_at [32];

  int tests = 0;
  int fails = 0;
  int nvalid, done_k;
  logic ws_bad, addr_bad, saw_bad;

  assign rom_data = rom_mem[rom_addr];
  assign ram_data = ram_mem[ram_addr];

  always #5 clk = ~clk;

  ram_unscramble_checker #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_cs_n(rom_cs_n), .rom_oe(rom_oe), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_cs_n(ram_cs_n), .ram_oe(ram_oe), .ram_ws(ram_ws), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .done(done), .dout(dout),
    .dout_valid(dout_valid), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  // Writer-side permutation, used to build the RAM image
  function automatic logic [7:0] scr(input logic [7:0] r);
    return {r[0], r[7], r[1], r[6], r[2], r[5], r[3], r[4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Launch one sweep, check every streamed byte, return pulse count and the
  // cycle (relative to start) in which done appeared (-1 if never).
  task automatic sweep(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                       input int max_k, input int inj_k,
                       output int nv, output int dk);
    int stable;
    logic prev_low;
    logic [ADDR_W-1:0] last_a, cur;
    nv = 0; dk = -1; stable = 0; prev_low = 1'b0; last_a = '0; cur = sa;
    @(negedge clk);
    start_addr = sa; end_addr = ea; start = 1'b1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) begin
        start_addr = 5'h00; end_addr = 5'h01;
      end
      if (ram_ws !== 1'b0) ws_bad = 1'b1;
      if (rom_addr !== ram_addr) addr_bad = 1'b1;
      if (ram_cs_n) stable = 0;
      else if (prev_low && ram_addr == last_a) stable++;
      else stable = 1;
      prev_low = !ram_cs_n;
      last_a   = ram_addr;
      if (dout_valid) begin
        chk("dout", {24'd0, dout}, {24'd0, exp_mem[cur]});
        chk("sample_addr", {27'd0, ram_addr}, {27'd0, cur});
        chk("addr_stable", stable, WAIT_CYC + 2);
        dout_at[cur] = dout;
        nv++;
        cur = cur + 1'b1;
      end
      if (done) begin
        dk = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    ws_bad = 1'b0; addr_bad = 1'b0; saw_bad = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rom_mem[a] = 8'(a * 29 + 7);
      exp_mem[a] = rom_mem[a];
      ram_mem[a] = scr(rom_mem[a]);
      dout_at[a] = 8'h00;
    end
    // Hand-computed permutation corner cases
    rom_mem[5] = 8'h01; ram_mem[5] = 8'h80; exp_mem[5] = 8'h01;
    rom_mem[6] = 8'h80; ram_mem[6] = 8'h40; exp_mem[6] = 8'h80;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rom_cs_n", {31'd0, rom_cs_n}, 1);
    chk("rst_ram_cs_n", {31'd0, ram_cs_n}, 1);
    chk("rst_oe", {30'd0, rom_oe, ram_oe}, 0);
    chk("rst_ws", {31'd0, ram_ws}, 0);
    chk("rst_addr", {22'd0, rom_addr, ram_addr}, 0);
    chk("rst_flags", {29'd0, busy, done, dout_valid}, 0);
    chk("rst_dout", {24'd0, dout}, 0);
    chk("rst_err", {26'd0, err_cnt}, 0);
    chk("rst_ferr", {27'd0, first_err_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep 0x04..0x1E
    sweep(5'h04, 5'h1E, 200, 0, nvalid, done_k);
    chk("clean_nvalid", nvalid, 27);
    chk("clean_done_k", done_k, 82);
    chk("clean_err", {26'd0, err_cnt}, 0);
    chk("perm5", {24'd0, dout_at[5]}, 32'h01);
    chk("perm6", {24'd0, dout_at[6]}, 32'h80);
    chk("clean_busy_done", {30'd0, busy, done}, 32'h1);

    // Corrupt two RAM bytes; a start pulse while busy must be ignored
    ram_mem[5'h09] = scr(rom_mem[5'h09]) ^ 8'h01;
    exp_mem[5'h09] = rom_mem[5'h09] ^ 8'h10;
    ram_mem[5'h12] = scr(rom_mem[5'h12]) ^ 8'h80;
    exp_mem[5'h12] = rom_mem[5'h12] ^ 8'h01;
    sweep(5'h04, 5'h1E, 200, 10, nvalid, done_k);
    chk("err_nvalid", nvalid, 27);
    chk("err_done_k", done_k, 82);
    chk("err_cnt", {26'd0, err_cnt}, 2);
    chk("err_first", {27'd0, first_err_addr}, 32'h09);

    // Results hold after done until the next accepted start
    repeat (5) @(negedge clk);
    chk("hold_err", {26'd0, err_cnt}, 2);
    chk("hold_first", {27'd0, first_err_addr}, 32'h09);
    chk("hold_idle", {29'd0, busy, done, ram_cs_n}, 1);

    // Empty range: done one cycle after start, count cleared, nothing streamed
    sweep(5'h10, 5'h08, 20, 0, nvalid, done_k);
    chk("empty_nvalid", nvalid, 0);
    chk("empty_done_k", done_k, 1);
    chk("empty_err", {26'd0, err_cnt}, 0);

    // Top address only: one check, no wrap
    sweep(5'h1F, 5'h1F, 20, 0, nvalid, done_k);
    chk("top_nvalid", nvalid, 1);
    chk("top_done_k", done_k, 4);
    chk("top_err", {26'd0, err_cnt}, 0);
    chk("top_ferr", {27'd0, first_err_addr}, 0);
    saw_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dout_valid || !ram_cs_n || done) saw_bad = 1'b1;
    end
    chk("top_no_wrap", {31'd0, saw_bad}, 0);

    chk("ws_never", {31'd0, ws_bad}, 0);
    chk("rom_ram_addr_eq", {31'd0, addr_bad}, 0);

    // Reset in WAIT of address 0x0A, after 0x09 has logged an error
    @(negedge clk);
    start_addr = 5'h09; end_addr = 5'h1F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_err", {26'd0, err_cnt}, 1);
    chk("pre_rst_addr", {27'd0, ram_addr}, 32'h0A);
    chk("pre_rst_cs", {31'd0, ram_cs_n}, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", {30'd0, rom_cs_n, ram_cs_n}, 3);
    chk("arst_oe", {30'd0, rom_oe, ram_oe}, 0);
    chk("arst_flags", {28'd0, busy, done, dout_valid, ram_ws}, 0);
    chk("arst_addr", {22'd0, rom_addr, ram_addr}, 0);
    chk("arst_err", {26'd0, err_cnt}, 0);
    chk("arst_ferr", {27'd0, first_err_addr}, 0);
    chk("arst_dout", {24'd0, dout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_bad = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done || dout_valid || busy) saw_bad = 1'b1;
    end
    chk("abandon_no_done", {31'd0, saw_bad}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_unscramble_checker.md
Name: ram_unscramble_checker

Overview:
Synchronous read-back engine for the scrambled ROM-to-RAM image.
- On start, walks an inclusive address range, reading the RAM and ROM at each address through their chip-select/output-enable interfaces.
- Applies the inverse of the write-side bit permutation to each RAM byte and compares the result with the ROM byte.
- Streams the recovered bytes out and reports the mismatch count and the first failing address.
- Sits between the control sequencer and the rom/ram models: it is the reader matching the scrambling writer.

Parameters:
ADDR_W, 5, address width of the rom/ram port and of all address ports.
WAIT_CYC, 1, cycles (≥1) address/CS/OE are held stable before data is sampled (async memory access time).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; accepted only in IDLE.
start_addr  input  ADDR_W  first address checked.
end_addr  input  ADDR_W  last address checked (inclusive).
rom_cs_n  output  1  ROM chip select, active low.
rom_oe  output  1  ROM output enable, active high.
rom_addr  output  ADDR_W  ROM address.
rom_data  input  8  ROM read data.
ram_cs_n  output  1  RAM chip select, active low.
ram_oe  output  1  RAM output enable, active high.
ram_ws  output  1  RAM write strobe; tied 0 (never writes).
ram_addr  output  ADDR_W  RAM address (same value as rom_addr).
ram_data  input  8  RAM read data (bench/board resolves the tristate).
busy  output  1  high from start acceptance until done.
done  output  1  one-cycle pulse at end of sweep.
dout  output  8  unscrambled RAM byte.
dout_valid  output  1  one-cycle pulse per address checked.
err_cnt  output  ADDR_W+1  mismatches in the current/last sweep; saturates at all-ones.
first_err_addr  output  ADDR_W  address of the first mismatch; valid when err_cnt≠0.

Behaviour:
Reset (async, rst_n=0):
- State IDLE.
- rom_cs_n=1, ram_cs_n=1, rom_oe=0, ram_oe=0, ram_ws=0.
- Addresses 0, busy=0, done=0, dout=0, dout_valid=0, err_cnt=0, first_err_addr=0.

Reset mid-sweep: same values immediately; the sweep is abandoned, with no done pulse.

Unscramble, with s = ram_data:
- dout[7:0] = {s[6],s[4],s[2],s[0],s[1],s[3],s[5],s[7]}.
- This is the exact inverse of the write mapping s = {r[0],r[7],r[1],r[6],r[2],r[5],r[3],r[4]}.

FSM states: IDLE, SETUP, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 with start_addr≤end_addr: latch the range, clear err_cnt and first_err_addr, set addr=start_addr, busy=1 → SETUP.
  - start=1 with start_addr>end_addr: clear err_cnt → DONE (zero bytes checked).
- SETUP (1 cycle): drive rom_addr=ram_addr=addr, both cs_n=0, both oe=1; load the wait counter with WAIT_CYC → WAIT.
- WAIT: decrement the counter; hold all controls. Counter reaches 0 → SAMPLE.
- SAMPLE (1 cycle): register dout=unscramble(ram_data) and pulse dout_valid=1.
  - If dout≠rom_data: if err_cnt==0, first_err_addr=addr; err_cnt increments unless saturated.
  - If addr==end_addr → DONE.
  - Otherwise addr+1 → SETUP; CS stays low and OE stays high across addresses.
- DONE (1 cycle): done=1, busy=0, both cs_n=1, both oe=0 → IDLE.

Timing and boundary rules:
- Addresses never wrap: end_addr = 2^ADDR_W−1 terminates on equality, with no overflow to 0.
- Latency per address is WAIT_CYC+2 cycles; a full sweep takes N·(WAIT_CYC+2)+1 cycles from start to done, where N = end_addr−start_addr+1.
- start while busy is ignored.
- start in the DONE cycle is ignored; start is accepted the following cycle.
- err_cnt and first_err_addr hold after done until the next accepted start.
- ram_ws stays 0 in every state, so the RAM bus is never driven by a write.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT → all outputs at reset values asynchronously, both cs_n=1, and no done pulse follows.
- Clean sweep: RAM preloaded with scramble(ROM) for 0x04..0x1E, start 0x04..0x1E, WAIT_CYC=1 → 27 dout_valid pulses, each dout equals ROM[addr], err_cnt=0, done 82 cycles after start.
- Permutation check: ROM[5]=0x01 with RAM[5]=0x80 → dout=0x01, no error. ROM[6]=0x80 with RAM[6]=0x40 → dout=0x80, no error.
- Errors: corrupt RAM[0x09] and RAM[0x12] → err_cnt=2, first_err_addr=0x09.
- Boundaries: start 0x1F..0x1F → one check, then done, with no wrap. Start 0x10..0x08 → done 1 cycle after start, err_cnt=0, and no dout_valid.
- Protocol: start pulsed while busy → ignored, sweep unchanged; ram_ws=0 throughout; addresses are stable for WAIT_CYC+1 cycles before each sample.
